// File: rtl/cam_pkg.sv
// Shared constants and types for the CAM block family.
// Covers default geometry, the read-FSM state encoding and the rank type.
package cam_pkg;

    localparam int CAM_DEPTH      = 16;
    localparam int CAM_WIDTH      = 8;
    localparam int CAM_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_RESP    = 2'd2,
        ST_PROMOTE = 2'd3
    } cam_state_t;

    typedef logic [CAM_ADDR_WIDTH-1:0] cam_rank_t;

endpackage

// File: rtl/cam_lru_rank.sv
// LRU rank table: one rank per slot, 0 = least recently used, DEPTH-1 = most.
// A promote strobe moves one slot to MRU; lru_addr names the slot at rank 0.
module cam_lru_rank
    import cam_pkg::*;
#(
    parameter int DEPTH      = CAM_DEPTH,
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             promote_en,
    input  logic [ADDR_WIDTH-1:0]            promote_idx,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0] rank,
    output logic [ADDR_WIDTH-1:0]            lru_addr
);

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] rank_q;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] rank_d;
    logic [ADDR_WIDTH-1:0]            sel_rank;

    assign sel_rank = rank_q[promote_idx];
    assign rank     = rank_q;

    // Only ranks above the promoted one shift down, so the table stays a permutation.
    always_comb begin
        rank_d = rank_q;
        if (promote_en) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ADDR_WIDTH'(i) == promote_idx) begin
                    rank_d[i] = ADDR_WIDTH'(DEPTH - 1);
                end else if (rank_q[i] > sel_rank) begin
                    rank_d[i] = rank_q[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        lru_addr = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rank_q[i] == '0) begin
                lru_addr = ADDR_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rank_q[i] <= ADDR_WIDTH'(i);
            end
        end else begin
            rank_q <= rank_d;
        end
    end

endmodule

// File: rtl/cam_index_reader.sv
// Index-addressed reader for the CAM store: slot index -> data, valid, LRU age.
// Fill port loads slots; a handshaked read hit promotes the slot to MRU.
module cam_index_reader
    import cam_pkg::*;
#(
    parameter int DEPTH      = CAM_DEPTH,
    parameter int WIDTH      = CAM_WIDTH,
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  wr_ready,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic                  rd_valid,
    input  logic                  rd_ack,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_hit,
    output logic [ADDR_WIDTH-1:0] rd_age,
    output logic [ADDR_WIDTH-1:0] lru_addr
);

    cam_state_t                       state_q, state_d;
    logic [DEPTH-1:0][WIDTH-1:0]      data_q, data_d;
    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
    logic                             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]                 rd_data_q, rd_data_d;
    logic                             rd_hit_q, rd_hit_d;
    logic [ADDR_WIDTH-1:0]            rd_age_q, rd_age_d;

    logic                             fill_acc;
    logic                             promote_en;
    logic [ADDR_WIDTH-1:0]            promote_idx;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] rank;

    assign wr_ready = (state_q != ST_PROMOTE);
    assign rd_ready = (state_q == ST_IDLE);
    assign fill_acc = wr_en && wr_ready;

    // Fill and PROMOTE are mutually exclusive, so one promotion per cycle at most.
    assign promote_en  = fill_acc || (state_q == ST_PROMOTE);
    assign promote_idx = (state_q == ST_PROMOTE) ? addr_q : wr_addr;

    cam_lru_rank #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rank (
        .clk         (clk),
        .reset       (reset),
        .promote_en  (promote_en),
        .promote_idx (promote_idx),
        .rank        (rank),
        .lru_addr    (lru_addr)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_hit_d   = rd_hit_q;
        rd_age_d   = rd_age_q;

        if (fill_acc) begin
            data_d[wr_addr]  = wr_data;
            valid_d[wr_addr] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    addr_d  = rd_addr;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // Age is sampled before any same-cycle fill promotes the slot.
                rd_age_d = rank[addr_q];
                if (fill_acc && (wr_addr == addr_q)) begin
                    rd_data_d = wr_data;
                    rd_hit_d  = 1'b1;
                end else begin
                    rd_data_d = valid_q[addr_q] ? data_q[addr_q] : '0;
                    rd_hit_d  = valid_q[addr_q];
                end
                rd_valid_d = 1'b1;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rd_ack) begin
                    rd_valid_d = 1'b0;
                    state_d    = rd_hit_q ? ST_PROMOTE : ST_IDLE;
                end
            end
            ST_PROMOTE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            valid_q    <= '0;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_hit_q   <= 1'b0;
            rd_age_q   <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_hit_q   <= rd_hit_d;
            rd_age_q   <= rd_age_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_hit   = rd_hit_q;
    assign rd_age   = rd_age_q;

endmodule

// File: tb/tb_cam_index_reader.sv
// Directed bench for cam_index_reader: fills, reads, bypass, snapshot hold,
// dropped fill during promotion and asynchronous reset mid-response.
module tb_cam_index_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_req;
    logic [3:0] rd_addr;
    logic       rd_ready;
    logic       rd_valid;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic       rd_hit;
    logic [3:0] rd_age;
    logic [3:0] lru_addr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cam_index_reader #(
        .DEPTH      (16),
        .WIDTH      (8),
        .ADDR_WIDTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .rd_hit   (rd_hit),
        .rd_age   (rd_age),
        .lru_addr (lru_addr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at a falling edge; inputs change there.
    task automatic do_fill(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic issue(input logic [3:0] a, input logic byp, input logic [7:0] bd);
        rd_req = 1'b1; rd_addr = a;
        @(negedge clk);
        rd_req = 1'b0;
        check_eq("lat_n1_valid", rd_valid, 0);
        if (byp) begin
            wr_en = 1'b1; wr_addr = a; wr_data = bd;
        end
        @(negedge clk);
        wr_en = 1'b0;
        check_eq("lat_n2_valid", rd_valid, 1);
    endtask

    task automatic ack(input logic hit);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        check_eq("ack_valid_low", rd_valid, 0);
        if (hit) begin
            check_eq("promote_wr_ready", wr_ready, 0);
            @(negedge clk);
            check_eq("post_promote_wr_ready", wr_ready, 1);
        end
        check_eq("idle_rd_ready", rd_ready, 1);
    endtask

    task automatic read_check(input string tag, input logic [3:0] a,
                              input logic [7:0] ed, input logic eh, input logic [3:0] ea);
        issue(a, 1'b0, 8'h00);
        check_eq({tag, "_data"}, rd_data, ed);
        check_eq({tag, "_hit"}, rd_hit, eh);
        check_eq({tag, "_age"}, rd_age, ea);
        ack(eh);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rd_addr = '0; rd_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_rd_hit", rd_hit, 0);
        check_eq("rst_rd_age", rd_age, 0);
        check_eq("rst_rd_ready", rd_ready, 1);
        check_eq("rst_wr_ready", wr_ready, 1);
        check_eq("rst_lru", lru_addr, 0);

        // Miss on an empty slot: no promotion.
        read_check("miss5", 4'd5, 8'h00, 1'b0, 4'd5);
        check_eq("miss5_lru", lru_addr, 0);

        // Slot 3 filled lands at MRU; slot 4 drops from rank 4 to 3.
        do_fill(4'd3, 8'hA5);
        read_check("hit3", 4'd3, 8'hA5, 1'b1, 4'd15);
        check_eq("hit3_lru", lru_addr, 0);
        read_check("age4", 4'd4, 8'h00, 1'b0, 4'd3);

        // Fills 0,1,2 then promote 0 from rank 13.
        do_fill(4'd0, 8'h10);
        check_eq("fill0_lru", lru_addr, 1);
        do_fill(4'd1, 8'h11);
        check_eq("fill1_lru", lru_addr, 2);
        do_fill(4'd2, 8'h12);
        check_eq("fill2_lru", lru_addr, 4);
        read_check("hit0", 4'd0, 8'h10, 1'b1, 4'd13);
        check_eq("hit0_lru", lru_addr, 4);
        read_check("age5", 4'd5, 8'h00, 1'b0, 4'd1);

        // Snapshot hold: read slot 1 (rank 13), fill 7 and ignored rd_req during RESP.
        issue(4'd1, 1'b0, 8'h00);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h77;
        rd_req = 1'b1; rd_addr = 4'd7;
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_data", rd_data, 8'h11);
            check_eq("hold_valid", rd_valid, 1);
            @(negedge clk);
            wr_en = 1'b0;
        end
        rd_req = 1'b0;
        check_eq("hold_age", rd_age, 13);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        check_eq("hold_ack_valid", rd_valid, 0);
        check_eq("hold_promote_wr_ready", wr_ready, 0);
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        check_eq("hold_wr_ready_back", wr_ready, 1);
        read_check("drop1", 4'd1, 8'h11, 1'b1, 4'd15);
        read_check("fill7", 4'd7, 8'h77, 1'b1, 4'd14);

        // Bypass: slot 9 (rank 4) filled in the READ cycle.
        issue(4'd9, 1'b1, 8'h99);
        check_eq("byp_data", rd_data, 8'h99);
        check_eq("byp_hit", rd_hit, 1);
        check_eq("byp_age", rd_age, 4);
        ack(1'b1);

        // Asynchronous reset while a response is pending.
        issue(4'd2, 1'b0, 8'h00);
        check_eq("pre_rst_hit", rd_hit, 1);
        #1 reset = 1'b1;
        #1;
        check_eq("async_rst_valid", rd_valid, 0);
        check_eq("async_rst_ready", rd_ready, 1);
        check_eq("async_rst_lru", lru_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", rd_ready, 1);
        read_check("post_rst2", 4'd2, 8'h00, 1'b0, 4'd2);
        read_check("post_rst9", 4'd9, 8'h00, 1'b0, 4'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
